// File: rtl/uart_rx_deserializer_pkg.sv
// uart_rx_deserializer_pkg
// Shared constants and types for the UART receive path.
//   - PARITY_* : parity mode encodings used by the PARITY parameter
//   - OVERSAMPLING_16 : default oversampling ratio shared with the baud generator
//   - rx_state_t : receive FSM state encoding
//   - parity_target() : value that XOR(data, parity bit) must equal for a mode
package uart_rx_deserializer_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   localparam int OVERSAMPLING_16 = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_t;

   // Odd parity: data bits plus parity bit contain an odd number of ones.
   function automatic logic parity_target(input int parity_mode);
      case (parity_mode)
         PARITY_ODD:  return 1'b1;
         PARITY_EVEN: return 1'b0;
         default:     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// bit_synchronizer
// Two-flop synchronizer per bit for asynchronous inputs, with a selectable
// reset value so idle-high lines (rx, cts) do not glitch low out of reset.
//   clk   : destination clock
//   reset : asynchronous active-high reset, loads RESET_VALUE into both stages
//   d     : asynchronous input(s)
//   q     : synchronized output(s), 2 clk latency
module bit_synchronizer #(
   parameter int   WIDTH       = 1,
   parameter logic RESET_VALUE = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_bit
         logic [1:0] stages_reg;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               stages_reg <= {2{RESET_VALUE}};
            end else begin
               stages_reg <= {stages_reg[0], d[gi]};
            end
         end

         assign q[gi] = stages_reg[1];
      end
   endgenerate

endmodule

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer
// Oversampled UART receiver: finds the start bit, samples each bit at its
// centre (LSB first), checks optional parity and the stop bit, and offers the
// result on a single-entry valid/ready holding register.
//   clk, reset  : clock and asynchronous active-high reset
//   rxTick      : one-clk enable at BAUD_RATE x OVERSAMPLING
//   rx          : asynchronous serial input, idle high
//   rxData      : held byte, valid while rxValid
//   rxValid     : holding register full
//   rxReady     : consumer accept (handshake on rxValid && rxReady)
//   parityError : parity mismatch for the held byte
//   frameError  : stop bit sampled low for the held byte
//   overrun     : one-clk pulse when a frame completes into a full holder
//   busy        : receiver FSM not idle
module uart_rx_deserializer
   import uart_rx_deserializer_pkg::*;
#(
   parameter int DATA_BITS    = 8,
   parameter int OVERSAMPLING = OVERSAMPLING_16,
   parameter int PARITY       = PARITY_NONE
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rxTick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rxData,
   output logic                 rxValid,
   input  logic                 rxReady,
   output logic                 parityError,
   output logic                 frameError,
   output logic                 overrun,
   output logic                 busy
);

   localparam int CW = $clog2(OVERSAMPLING);
   localparam int BW = $clog2(DATA_BITS + 1);

   localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLING / 2 - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLING - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] IDX_ONE  = BW'(1);

   localparam logic PARITY_EN  = (PARITY != PARITY_NONE);
   localparam logic PARITY_REF = parity_target(PARITY);

   // ---------------------------------------------------------------
   // Input synchronizer
   // ---------------------------------------------------------------
   logic rx_sync;

   bit_synchronizer #(
      .WIDTH       (1),
      .RESET_VALUE (1'b1)
   ) u_rx_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx),
      .q     (rx_sync)
   );

   // ---------------------------------------------------------------
   // Receive FSM
   // ---------------------------------------------------------------
   rx_state_t            state_reg,      state_next;
   logic [CW-1:0]        sample_cnt_reg, sample_cnt_next;
   logic [BW-1:0]        bit_idx_reg,    bit_idx_next;
   logic [DATA_BITS-1:0] shift_reg,      shift_next;
   logic                 parity_bad_reg, parity_bad_next;
   logic                 commit;
   logic                 commit_frame_error;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         sample_cnt_reg <= '0;
         bit_idx_reg    <= '0;
         shift_reg      <= '0;
         parity_bad_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         sample_cnt_reg <= sample_cnt_next;
         bit_idx_reg    <= bit_idx_next;
         shift_reg      <= shift_next;
         parity_bad_reg <= parity_bad_next;
      end
   end

   always_comb begin
      state_next         = state_reg;
      sample_cnt_next    = sample_cnt_reg;
      bit_idx_next       = bit_idx_reg;
      shift_next         = shift_reg;
      parity_bad_next    = parity_bad_reg;
      commit             = 1'b0;
      commit_frame_error = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (rxTick && !rx_sync) begin
               sample_cnt_next = '0;
               parity_bad_next = 1'b0;
               state_next      = ST_START;
            end
         end

         // Re-check the line half a bit in; a high sample means the falling
         // edge was noise, so drop back without producing anything.
         ST_START: begin
            if (rxTick) begin
               if (sample_cnt_reg == CNT_MID) begin
                  if (!rx_sync) begin
                     sample_cnt_next = '0;
                     bit_idx_next    = '0;
                     state_next      = ST_DATA;
                  end else begin
                     state_next = ST_IDLE;
                  end
               end else begin
                  sample_cnt_next = sample_cnt_reg + CNT_ONE;
               end
            end
         end

         // Samples are a full bit apart from the start-bit centre, so each
         // one lands mid-bit. LSB arrives first, hence the right shift.
         ST_DATA: begin
            if (rxTick) begin
               if (sample_cnt_reg == CNT_LAST) begin
                  sample_cnt_next = '0;
                  shift_next      = {rx_sync, shift_reg[DATA_BITS-1:1]};
                  bit_idx_next    = bit_idx_reg + IDX_ONE;
                  if (bit_idx_reg == IDX_LAST) begin
                     state_next = PARITY_EN ? ST_PARITY : ST_STOP;
                  end
               end else begin
                  sample_cnt_next = sample_cnt_reg + CNT_ONE;
               end
            end
         end

         ST_PARITY: begin
            if (rxTick) begin
               if (sample_cnt_reg == CNT_LAST) begin
                  sample_cnt_next = '0;
                  parity_bad_next = ((^shift_reg) ^ rx_sync) != PARITY_REF;
                  state_next      = ST_STOP;
               end else begin
                  sample_cnt_next = sample_cnt_reg + CNT_ONE;
               end
            end
         end

         // Leave at the stop-bit centre rather than its end so a following
         // start edge half a bit later is still caught.
         ST_STOP: begin
            if (rxTick) begin
               if (sample_cnt_reg == CNT_LAST) begin
                  sample_cnt_next    = '0;
                  commit             = 1'b1;
                  commit_frame_error = !rx_sync;
                  state_next         = ST_IDLE;
               end else begin
                  sample_cnt_next = sample_cnt_reg + CNT_ONE;
               end
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Holding register and handshake
   // ---------------------------------------------------------------
   logic [DATA_BITS-1:0] data_reg,         data_next;
   logic                 valid_reg,        valid_next;
   logic                 parity_error_reg, parity_error_next;
   logic                 frame_error_reg,  frame_error_next;
   logic                 overrun_reg,      overrun_next;
   logic                 handshake;

   assign handshake = valid_reg && rxReady;

   always_comb begin
      data_next         = data_reg;
      valid_next        = valid_reg && !handshake;
      parity_error_next = parity_error_reg;
      frame_error_next  = frame_error_reg;
      overrun_next      = 1'b0;

      if (commit) begin
         // A same-cycle accept frees the slot, so the new frame still lands.
         if (!valid_reg || handshake) begin
            data_next         = shift_reg;
            parity_error_next = parity_bad_reg;
            frame_error_next  = commit_frame_error;
            valid_next        = 1'b1;
         end else begin
            overrun_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_reg         <= '0;
         valid_reg        <= 1'b0;
         parity_error_reg <= 1'b0;
         frame_error_reg  <= 1'b0;
         overrun_reg      <= 1'b0;
      end else begin
         data_reg         <= data_next;
         valid_reg        <= valid_next;
         parity_error_reg <= parity_error_next;
         frame_error_reg  <= frame_error_next;
         overrun_reg      <= overrun_next;
      end
   end

   assign rxData      = data_reg;
   assign rxValid     = valid_reg;
   assign parityError = parity_error_reg;
   assign frameError  = frame_error_reg;
   assign overrun     = overrun_reg;
   assign busy        = (state_reg != ST_IDLE);

endmodule
